// File: rtl/sdram_avalon_if.sv
// Avalon-MM command/response bundle seen by the SDRAM responder.
// Mirrors the active-low command signals of the SDRAM controller.
interface sdram_avalon_if #(
    parameter int unsigned ADDR_W = 25,
    parameter int unsigned DATA_W = 16
);
    logic [ADDR_W-1:0] sdram_address;
    logic [1:0]        sdram_byteenable_n;
    logic              sdram_chipselect;
    logic [DATA_W-1:0] sdram_writedata;
    logic              sdram_read_n;
    logic              sdram_write_n;
    logic [DATA_W-1:0] sdram_readdata;
    logic              sdram_readdatavalid;
    logic              sdram_waitrequest;

    modport master (
        output sdram_address, sdram_byteenable_n, sdram_chipselect,
        output sdram_writedata, sdram_read_n, sdram_write_n,
        input  sdram_readdata, sdram_readdatavalid, sdram_waitrequest
    );

    modport slave (
        input  sdram_address, sdram_byteenable_n, sdram_chipselect,
        input  sdram_writedata, sdram_read_n, sdram_write_n,
        output sdram_readdata, sdram_readdatavalid, sdram_waitrequest
    );
endinterface

// File: rtl/sdram_avalon_responder.sv
// On-chip-RAM stand-in for the SDRAM controller: command stalls, fixed
// pipelined read latency and periodic refresh blackouts.
module sdram_avalon_responder #(
    parameter int unsigned ADDR_W         = 25,
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned MEM_DEPTH_LOG2 = 10,
    parameter int unsigned READ_LATENCY   = 3,
    parameter int unsigned WAIT_CYCLES    = 1,
    parameter int unsigned REFRESH_PERIOD = 390,
    parameter int unsigned REFRESH_CYCLES = 8
) (
    input  logic           clk,
    input  logic           reset,
    sdram_avalon_if.slave  bus,
    output logic           refresh_active,
    output logic           protocol_error
);
    localparam int unsigned LANE_W    = DATA_W / 2;
    localparam int unsigned MEM_DEPTH = 1 << MEM_DEPTH_LOG2;
    localparam int unsigned CNT_MAX   = (REFRESH_CYCLES > WAIT_CYCLES) ? REFRESH_CYCLES : WAIT_CYCLES;
    localparam int unsigned CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned TMR_W     = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] STALL   = 2'd1;
    localparam logic [1:0] REFRESH = 2'd2;

    logic [1:0]                state, state_next;
    logic [CNT_W-1:0]          cnt, cnt_next;
    logic                      wait_c, pending_clr_c;
    logic                      request_c, accept_c, wr_acc_c, rd_acc_c, illegal_c;
    logic                      refresh_pending;
    logic [TMR_W-1:0]          tmr;
    logic [MEM_DEPTH_LOG2-1:0] idx;
    logic [DATA_W-1:0]         mem [MEM_DEPTH];
    logic [READ_LATENCY-1:0]   pipe_vld;
    logic [DATA_W-1:0]         pipe_dat [READ_LATENCY];
    logic                      unused_addr;

    // Upper address bits alias onto the RAM.
    assign idx         = bus.sdram_address[MEM_DEPTH_LOG2-1:0];
    assign unused_addr = ^bus.sdram_address[ADDR_W-1:MEM_DEPTH_LOG2];

    assign request_c = bus.sdram_chipselect & (~bus.sdram_read_n | ~bus.sdram_write_n);
    assign accept_c  = request_c & ~wait_c;
    assign illegal_c = accept_c & ~bus.sdram_read_n & ~bus.sdram_write_n;
    assign wr_acc_c  = accept_c & ~bus.sdram_write_n & ~reset;
    assign rd_acc_c  = accept_c & ~bus.sdram_read_n & bus.sdram_write_n;

    assign bus.sdram_waitrequest   = wait_c;
    assign bus.sdram_readdatavalid = pipe_vld[READ_LATENCY-1];
    assign bus.sdram_readdata      = pipe_dat[READ_LATENCY-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Refresh has priority in IDLE only; an open STALL always completes.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        wait_c        = 1'b0;
        pending_clr_c = 1'b0;
        case (state)
            IDLE: begin
                if (refresh_pending) begin
                    wait_c        = 1'b1;
                    cnt_next      = CNT_W'(REFRESH_CYCLES - 1);
                    pending_clr_c = 1'b1;
                    state_next    = REFRESH;
                end else if (request_c && (WAIT_CYCLES != 0)) begin
                    wait_c     = 1'b1;
                    cnt_next   = CNT_W'(WAIT_CYCLES - 1);
                    state_next = STALL;
                end
            end
            STALL: begin
                if (cnt != '0) begin
                    wait_c   = 1'b1;
                    cnt_next = cnt - CNT_W'(1);
                end else begin
                    state_next = IDLE;
                end
            end
            REFRESH: begin
                wait_c = 1'b1;
                if (cnt != '0) begin
                    cnt_next = cnt - CNT_W'(1);
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Free-running refresh timer; a wrap coinciding with a clear keeps the request.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmr             <= '0;
            refresh_pending <= 1'b0;
        end else begin
            if (pending_clr_c) begin
                refresh_pending <= 1'b0;
            end
            if (REFRESH_PERIOD != 0) begin
                if (tmr == TMR_W'(REFRESH_PERIOD - 1)) begin
                    tmr             <= '0;
                    refresh_pending <= 1'b1;
                end else begin
                    tmr <= tmr + TMR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_active <= 1'b0;
            protocol_error <= 1'b0;
        end else begin
            refresh_active <= (state_next == REFRESH);
            if (illegal_c) begin
                protocol_error <= 1'b1;
            end
        end
    end

    // Backing RAM is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_acc_c) begin
            if (!bus.sdram_byteenable_n[0]) begin
                mem[idx][LANE_W-1:0] <= bus.sdram_writedata[LANE_W-1:0];
            end
            if (!bus.sdram_byteenable_n[1]) begin
                mem[idx][DATA_W-1:LANE_W] <= bus.sdram_writedata[DATA_W-1:LANE_W];
            end
        end
    end

    // Data is captured at accept so later writes cannot disturb it; idle slots carry zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_vld <= '0;
            for (int i = 0; i < int'(READ_LATENCY); i++) begin
                pipe_dat[i] <= '0;
            end
        end else begin
            for (int i = int'(READ_LATENCY) - 1; i > 0; i--) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_dat[i] <= pipe_dat[i-1];
            end
            pipe_vld[0] <= rd_acc_c;
            pipe_dat[0] <= rd_acc_c ? mem[idx] : '0;
        end
    end
endmodule

// File: doc/sdram_avalon_responder.md
# sdram_avalon_responder

Synthesizable Avalon-MM slave that answers the same active-low command interface the SDRAM controller presents to `sdram_interface` (`sdram_*` signals). It is backed by on-chip RAM and produces realistic controller timing: command stalls via `sdram_waitrequest`, fixed pipelined read latency via `sdram_readdatavalid`, and periodic refresh blackouts. It replaces the SDRAM controller in simulation and in FPGA bring-up, so `sdram_interface` and the test sequencers can be exercised without external SDRAM.

## Interface
- `ADDR_W`, 25, width of `sdram_address`
- `DATA_W`, 16, data width; must equal 16 (two byte lanes)
- `MEM_DEPTH_LOG2`, 10, log2 of backing RAM depth in words
- `READ_LATENCY`, 3, cycles from read acceptance to `sdram_readdatavalid` (1..7)
- `WAIT_CYCLES`, 1, waitrequest cycles inserted per command (0..7)
- `REFRESH_PERIOD`, 390, cycles between refresh requests; 0 disables refresh; otherwise > `REFRESH_CYCLES`+8
- `REFRESH_CYCLES`, 8, length of the REFRESH state in cycles (≥1)

Ports:
- `clk` in 1: single clock, all logic on rising edge
- `reset` in 1: synchronous, active-high reset
- `sdram_address` in `ADDR_W`: word address
- `sdram_byteenable_n` in 2: active-low byte enables, bit0 = [7:0], bit1 = [15:8]
- `sdram_chipselect` in 1: command qualifier
- `sdram_writedata` in 16: write data
- `sdram_read_n` in 1: active-low read request
- `sdram_write_n` in 1: active-low write request
- `sdram_readdata` out 16: read data, valid only with `sdram_readdatavalid`
- `sdram_readdatavalid` out 1: one-cycle pulse per accepted read
- `sdram_waitrequest` out 1: command not accepted this cycle
- `refresh_active` out 1: high while in REFRESH
- `protocol_error` out 1: sticky; set on illegal command

## Operation
- Request = `sdram_chipselect` & (!`sdram_read_n` | !`sdram_write_n`). A command is accepted on an edge where request & !`sdram_waitrequest`. The master must hold the command stable until accepted.
- Word index = `sdram_address[MEM_DEPTH_LOG2-1:0]`. Upper bits are ignored and alias; 25'h100000 maps to index 0.
- FSM states are IDLE, STALL and REFRESH; the state resets to IDLE. `sdram_waitrequest` is combinational from state, counter and request.
  - IDLE with `refresh_pending`: waitrequest=1; load cnt=`REFRESH_CYCLES`-1; clear pending; go to REFRESH.
  - IDLE with request and `WAIT_CYCLES`=0: waitrequest=0; accept; stay in IDLE.
  - IDLE with request and `WAIT_CYCLES`>0: waitrequest=1; load cnt=`WAIT_CYCLES`-1; go to STALL.
  - IDLE with no request: waitrequest=0.
  - STALL: waitrequest=(cnt≠0) and cnt decrements. At cnt=0, waitrequest=0, the command is accepted, and the FSM returns to IDLE. Refresh never preempts STALL.
  - REFRESH: waitrequest=1 and `refresh_active`=1. cnt decrements; at cnt=0 the FSM goes to IDLE.
- Refresh timer runs free from 0 to `REFRESH_PERIOD`-1 and wraps. On wrap it sets `refresh_pending`. The timer is inactive when `REFRESH_PERIOD`=0.
- Write acceptance: on the accept edge, each lane with a 0 in `sdram_byteenable_n` is updated. `sdram_byteenable_n`=2'b11 is accepted as a no-op.
- Read acceptance: the RAM word is sampled on the accept edge into a valid/data shift pipeline of depth `READ_LATENCY`.
  - One read can be accepted per cycle.
  - Responses return strictly in order.
  - A later write does not affect data already sampled.
- Read pipeline advances in every state, including REFRESH and STALL.
- Read and write both low while selected: the write is performed, the read is dropped (no `sdram_readdatavalid`), and `protocol_error` is set until reset.
- `sdram_readdata` = pipeline head data when valid, else 16'h0000.

## Timing
- Reset values:
  - Outputs: `sdram_readdatavalid`=0, `sdram_readdata`=0, `refresh_active`=0, `protocol_error`=0.
  - Internal state: FSM=IDLE, refresh timer=0, `refresh_pending`=0, all pipeline valid bits cleared.
  - RAM contents are not reset.
  - `sdram_waitrequest` follows the IDLE rule in the first cycle after reset.
- Command first presented at cycle t from IDLE with no pending refresh: accepted at cycle t+`WAIT_CYCLES`.
- Read accepted at cycle t: `sdram_readdatavalid` is high exactly at cycle t+`READ_LATENCY`, for one cycle.
- Refresh pending at cycle t while in IDLE: waitrequest is high from t to t+`REFRESH_CYCLES`. A waiting command then sees the normal `WAIT_CYCLES` stall.
- Reset mid-operation: in-flight reads are discarded and no `sdram_readdatavalid` follows. A write is committed only if its accept edge preceded reset.
- Throughput with `WAIT_CYCLES`=0: one command per cycle. Otherwise one command per `WAIT_CYCLES`+1 cycles.

## Test plan
- Defaults: write 16'h0042 at 25'h100000 with byteenable_n 00, then read the same address → waitrequest high for 1 cycle per command; readdatavalid exactly 3 cycles after read acceptance; readdata=16'h0042.
- Write 16'hABCD with byteenable_n 00, then 16'h1234 with byteenable_n 10, to address 5 → read returns 16'hAB34. A following write with byteenable_n 11 leaves the value at 16'hAB34.
- `WAIT_CYCLES`=0: preload 1111/2222/3333 at addresses 0/1/2, then issue back-to-back reads → waitrequest never asserts; readdatavalid is high for 3 consecutive cycles with data 1111, 2222, 3333 in order.
- `REFRESH_PERIOD`=16, `REFRESH_CYCLES`=4:
  - Present a read at the cycle `refresh_pending` rises → waitrequest high for 5 cycles plus 1 stall cycle; `refresh_active` high for exactly 4 cycles.
  - A read accepted just before the refresh still returns on schedule.
- read_n=write_n=0 with data 16'h00FF to address 7 → address 7 reads back 16'h00FF; no readdatavalid for the illegal command; `protocol_error`=1 until reset.
- Assert reset for 1 cycle, one cycle after a read is accepted → no readdatavalid ever appears; all outputs return to reset values; RAM data written before reset is preserved.
